// File: rtl/ac97_cmd_arbiter.sv
// AC'97 slot-1/slot-2 command arbiter: shares the codec register-write
// path between NREQ requesters, applying commands on frame boundaries.
//
// Ports:
//   BIT_CLK, SYSTEM_RESET   clock, synchronous active-high reset
//   frame_sig               one-cycle pulse per AC'97 frame
//   req/req_addr/req_data   per-requester level request, 7b index, 16b data
//   ack                     one-cycle completion pulse to the winner
//   grant                   one-hot owner of the latched/active command
//   busy                    high whenever not idle
//   CMD_ADDR/CMD_DATA       slot-1 / slot-2 words to the controller
//   cmd_count               completed writes since reset (wraps)
module ac97_cmd_arbiter #(
    parameter int         NREQ        = 3,
    parameter int         HOLD_FRAMES = 2,
    parameter logic [6:0] IDLE_REG    = 7'h26
) (
    input  logic                 BIT_CLK,
    input  logic                 SYSTEM_RESET,
    input  logic                 frame_sig,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*7-1:0]    req_addr,
    input  logic [NREQ*16-1:0]   req_data,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [19:0]          CMD_ADDR,
    output logic [19:0]          CMD_DATA,
    output logic [7:0]           cmd_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [19:0] IDLE_ADDR = {1'b1, IDLE_REG, 12'h000};

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        HOLD
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   win, win_n;
    logic [PW-1:0]   rr_ptr, rr_ptr_n;
    logic [3:0]      frame_cnt, frame_cnt_n;
    logic [6:0]      lat_addr, lat_addr_n;
    logic [15:0]     lat_data, lat_data_n;
    logic [NREQ-1:0] ack_n, grant_n;
    logic [19:0]     cmd_addr_n, cmd_data_n;
    logic [7:0]      cmd_count_n;

    logic            pick_vld;
    logic [PW-1:0]   pick_idx;

    // Requester 0 wins outright; otherwise the first requester found
    // scanning 1..NREQ-1 from rr_ptr. Descending scan lets the closest
    // candidate to rr_ptr overwrite the others.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        if (req[0]) begin
            pick_vld = 1'b1;
        end else begin
            for (int k = NREQ - 2; k >= 0; k--) begin
                idx = ((int'(rr_ptr) - 1 + k) % (NREQ - 1)) + 1;
                if (req[idx]) begin
                    pick_vld = 1'b1;
                    pick_idx = PW'(idx);
                end
            end
        end
    end

    always_comb begin
        state_n     = state;
        win_n       = win;
        rr_ptr_n    = rr_ptr;
        frame_cnt_n = frame_cnt;
        lat_addr_n  = lat_addr;
        lat_data_n  = lat_data;
        ack_n       = '0;
        grant_n     = grant;
        cmd_addr_n  = CMD_ADDR;
        cmd_data_n  = CMD_DATA;
        cmd_count_n = cmd_count;
        case (state)
            IDLE: begin
                // The ack cycle is skipped so a requester that still
                // holds req is only re-arbitrated a cycle later.
                if (ack == '0 && pick_vld) begin
                    win_n      = pick_idx;
                    lat_addr_n = req_addr[7*int'(pick_idx) +: 7];
                    lat_data_n = req_data[16*int'(pick_idx) +: 16];
                    grant_n    = NREQ'(1) << pick_idx;
                    state_n    = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (frame_sig) begin
                    cmd_addr_n  = {1'b0, lat_addr, 12'h000};
                    cmd_data_n  = {lat_data, 4'h0};
                    frame_cnt_n = '0;
                    state_n     = HOLD;
                end
            end
            HOLD: begin
                if (frame_sig) begin
                    if (frame_cnt == 4'(HOLD_FRAMES - 1)) begin
                        ack_n       = grant;
                        grant_n     = '0;
                        cmd_addr_n  = IDLE_ADDR;
                        cmd_data_n  = 20'h00000;
                        cmd_count_n = cmd_count + 8'd1;
                        state_n     = IDLE;
                        if (win != '0) begin
                            rr_ptr_n = (win == PW'(NREQ - 1)) ?
                                       PW'(1) : win + PW'(1);
                        end
                    end else begin
                        frame_cnt_n = frame_cnt + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge BIT_CLK) begin
        if (SYSTEM_RESET) begin
            state     <= IDLE;
            win       <= '0;
            rr_ptr    <= PW'(1);
            frame_cnt <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            ack       <= '0;
            grant     <= '0;
            CMD_ADDR  <= IDLE_ADDR;
            CMD_DATA  <= 20'h00000;
            cmd_count <= '0;
        end else begin
            state     <= state_n;
            win       <= win_n;
            rr_ptr    <= rr_ptr_n;
            frame_cnt <= frame_cnt_n;
            lat_addr  <= lat_addr_n;
            lat_data  <= lat_data_n;
            ack       <= ack_n;
            grant     <= grant_n;
            CMD_ADDR  <= cmd_addr_n;
            CMD_DATA  <= cmd_data_n;
            cmd_count <= cmd_count_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/ac97_cmd_arbiter.md
Name: ac97_cmd_arbiter

Overview:
- Shares the single AC'97 slot-1/slot-2 command path (CMD_ADDR/CMD_DATA into the codec controller) between several register-write requesters, e.g. codec init sequencer, volume control, mixer/input-select control.
- Arbitrates on request, applies commands only at frame boundaries (frame_sig), holds each command for a fixed number of frames, then acknowledges the requester.
- Sits between the requesters and the ac97 controller, clocked on BIT_CLK.

Parameters:
- NREQ, 3, number of requesters (2..8); requester 0 is the high-priority init port.
- HOLD_FRAMES, 2, frame_sig pulses a command stays on CMD_ADDR/CMD_DATA (1..15).
- IDLE_REG, 7'h26, register index read when no write is pending (powerdown/status poll).

Ports:
- BIT_CLK  in  1  codec bit clock; the only clock.
- SYSTEM_RESET  in  1  synchronous, active-high reset.
- frame_sig  in  1  one-cycle pulse per AC'97 frame from the controller.
- req  in  NREQ  per-requester write request, level.
- req_addr  in  NREQ*7  packed register indices; requester i uses bits [7i+6:7i].
- req_data  in  NREQ*16  packed write data; requester i uses bits [16i+15:16i].
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- grant  out  NREQ  one-hot; identifies the requester whose command is latched or active.
- busy  out  1  high whenever state is not IDLE.
- CMD_ADDR  out  20  slot-1 word: [19]=R/W (1=read), [18:12]=index, [11:0]=0.
- CMD_DATA  out  20  slot-2 word: [19:4]=data, [3:0]=0.
- cmd_count  out  8  writes completed since reset, wraps 255->0.

Behaviour:
- Reset (synchronous, SYSTEM_RESET=1 at a BIT_CLK edge) forces:
  - state=IDLE, ack=0, grant=0, busy=0, cmd_count=0, rr_ptr=1.
  - CMD_ADDR={1'b1,IDLE_REG,12'h000}, CMD_DATA=20'h00000.
  - Reset mid-operation aborts silently: no ack is issued, and the requester must keep req high to retry.
- Registered outputs only; no combinational path from req to any output.
- State IDLE:
  - If any req bit is high, pick a winner. req[0] wins outright; otherwise round-robin over 1..NREQ-1 starting at rr_ptr.
  - Latch the winner's addr/data, set grant one-hot, go to WAIT_FRAME.
  - No req: stay in IDLE; CMD_ADDR/CMD_DATA hold the idle read value.
- State WAIT_FRAME, on frame_sig:
  - CMD_ADDR<={1'b0,addr,12'h000}, CMD_DATA<={data,4'h0}.
  - frame_cnt<=0, go to HOLD.
  - The command therefore changes on the cycle after a frame_sig pulse and is stable for the whole next frame.
- State HOLD, on each frame_sig:
  - If frame_cnt==HOLD_FRAMES-1: pulse ack[winner] for exactly one cycle, restore the idle read on CMD_ADDR/CMD_DATA, clear grant, increment cmd_count, go to IDLE.
  - If the winner was non-zero, set rr_ptr to winner+1, wrapping NREQ-1->1. A req[0] win leaves rr_ptr unchanged.
  - Otherwise frame_cnt<=frame_cnt+1.
- Handshake:
  - Requester holds req, req_addr and req_data stable until ack.
  - Data is latched at grant, so later changes to req_addr/req_data have no effect.
  - Dropping req after grant does not abort the command, and ack is still pulsed.
- Back-to-back: req still high in the ack cycle is not re-arbitrated that cycle. Arbitration resumes the next cycle in IDLE, and the requester must deassert on ack to avoid a duplicate write.
- frame_sig and req arriving in the same cycle while IDLE: the grant is taken that cycle, and the command waits for the next frame_sig. The current pulse is not used.
- frame_sig pulses are counted only in WAIT_FRAME/HOLD and ignored in IDLE.
- Latency: grant 1 cycle after req; ack HOLD_FRAMES+1 frame_sig pulses after grant.

Test Plan:
- Reset then idle for 3 frames -> CMD_ADDR=20'hA6000, CMD_DATA=0, busy=0, ack=0, cmd_count=0.
- req[1]=1, addr=7'h02, data=16'h0808, HOLD_FRAMES=2:
  - grant=3'b010 next cycle.
  - After 1st frame_sig: CMD_ADDR=20'h02000, CMD_DATA=20'h08080.
  - ack[1] pulses one cycle after the 3rd frame_sig.
  - CMD returns to 20'hA6000; cmd_count=1.
- req[1] and req[2] held continuously, each dropping for one cycle after its ack -> grants alternate 1,2,1,2. Then raise req[0] mid-command -> req[0] is granted immediately after the current ack, ahead of both.
- Requester 2 changes req_data and drops req after grant -> the originally latched data is issued and ack[2] still pulses.
- SYSTEM_RESET asserted during HOLD -> next cycle: idle read command, grant=0, no ack pulse. With req[1] still high, the command restarts from WAIT_FRAME.
- 256 completed commands -> cmd_count wraps to 0.
